// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - minutes:seconds BCD stopwatch counting stage with run/pause and field adjust
module stopwatch_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       adjust,
    input  logic       select,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       wrap
);

    // BCD digits of the highest minutes value before the minutes field rolls over
    localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       wrap_q, wrap_d;

    logic       active_tick;
    logic       advance;
    logic       sec_at_max;
    logic       min_at_max;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;

    // Seconds field +1 in BCD, 59 rolls to 00
    function automatic logic [7:0] inc_sec(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones != 4'd9) begin
            r = {tens, ones + 4'd1};
        end else if (tens != 4'd5) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    // Minutes field +1 in BCD, MIN_MAX rolls to 00
    function automatic logic [7:0] inc_min(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (tens == MAX_TENS && ones == MAX_ONES) begin
            r = 8'h00;
        end else if (ones != 4'd9) begin
            r = {tens, ones + 4'd1};
        end else begin
            r = {tens + 4'd1, 4'd0};
        end
        return r;
    endfunction

    // State register: RUN after reset, pause pulses toggle it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only a pause pulse moves the machine
    always_comb begin
        state_d = state_q;
        if (pause) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Output decode: running reflects the registered state
    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Tick selection by mode; qualified by the pre-toggle state so a same-cycle pause acts afterwards
    always_comb begin
        active_tick = adjust ? tick_2hz : tick_1hz;
        advance     = active_tick && (state_q == ST_RUN);
        sec_at_max  = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
        min_at_max  = (min_tens_q == MAX_TENS) && (min_ones_q == MAX_ONES);
        sec_inc     = inc_sec(sec_tens_q, sec_ones_q);
        min_inc     = inc_min(min_tens_q, min_ones_q);
    end

    // Next count: carry chain in normal mode, single field without carry in adjust mode
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        wrap_d     = 1'b0;
        if (advance) begin
            if (adjust) begin
                if (select) begin
                    {sec_tens_d, sec_ones_d} = sec_inc;
                end else begin
                    {min_tens_d, min_ones_d} = min_inc;
                end
            end else begin
                {sec_tens_d, sec_ones_d} = sec_inc;
                if (sec_at_max) begin
                    {min_tens_d, min_ones_d} = min_inc;
                    wrap_d = min_at_max;
                end
            end
        end
    end

    // Count and wrap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            wrap_q     <= wrap_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       adjust = 1'b0;
    logic       select = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int wrap_count = 0;

    logic [15:0] digits;
    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    stopwatch_counter #(.MIN_MAX(59)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .adjust   (adjust),
        .select   (select),
        .pause    (pause),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_count = wrap_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        wrap_count = 0;
    endtask

    task automatic t1(input int n);
        repeat (n) begin
            @(negedge clk) tick_1hz = 1'b1;
            @(negedge clk) tick_1hz = 1'b0;
        end
    endtask

    task automatic t2(input int n);
        repeat (n) begin
            @(negedge clk) tick_2hz = 1'b1;
            @(negedge clk) tick_2hz = 1'b0;
        end
    endtask

    task automatic pause_pulse();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
    endtask

    // Load mm:ss via adjust mode, leaving adjust=0
    task automatic load(input int mm, input int ss);
        adjust = 1'b1;
        select = 1'b0;
        t2(mm);
        select = 1'b1;
        t2(ss);
        adjust = 1'b0;
        select = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_digits", 32'(digits), 32'h0000);
        chk("reset_running", 32'(running), 32'd1);
        chk("reset_wrap", 32'(wrap), 32'd0);
        @(negedge clk) rst = 1'b0;
        wrap_count = 0;

        // 75 normal ticks
        t1(75);
        chk("count75_digits", 32'(digits), 32'h0115);
        chk("count75_running", 32'(running), 32'd1);
        chk("count75_nowrap", 32'(wrap_count), 32'd0);

        // wrap at 59:59
        do_reset();
        load(59, 58);
        chk("preload_5958", 32'(digits), 32'h5958);
        t1(1);
        chk("wrap_5959", 32'(digits), 32'h5959);
        chk("wrap_low_5959", 32'(wrap), 32'd0);
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        chk("wrap_0000", 32'(digits), 32'h0000);
        chk("wrap_high", 32'(wrap), 32'd1);
        @(negedge clk);
        chk("wrap_drop", 32'(wrap), 32'd0);
        chk("wrap_once", 32'(wrap_count), 32'd1);

        // pause / resume
        do_reset();
        t1(10);
        chk("pre_pause", 32'(digits), 32'h0010);
        pause_pulse();
        chk("paused_running", 32'(running), 32'd0);
        t1(5);
        chk("paused_hold", 32'(digits), 32'h0010);
        adjust = 1'b1;
        t2(2);
        adjust = 1'b0;
        chk("paused_adjust_hold", 32'(digits), 32'h0010);
        pause_pulse();
        chk("resumed_running", 32'(running), 32'd1);
        t1(1);
        chk("resumed_count", 32'(digits), 32'h0011);

        // adjust seconds with 1 Hz ticks interleaved
        do_reset();
        load(0, 58);
        adjust = 1'b1;
        select = 1'b1;
        t2(1);
        chk("adjsec_0059", 32'(digits), 32'h0059);
        t1(1);
        chk("adjsec_ign1hz", 32'(digits), 32'h0059);
        t2(1);
        chk("adjsec_0000", 32'(digits), 32'h0000);
        t1(1);
        t2(1);
        chk("adjsec_0001", 32'(digits), 32'h0001);
        chk("adjsec_nowrap", 32'(wrap_count), 32'd0);

        // adjust minutes, then back to normal
        do_reset();
        load(58, 30);
        adjust = 1'b1;
        select = 1'b0;
        t2(1);
        chk("adjmin_5930", 32'(digits), 32'h5930);
        t2(1);
        chk("adjmin_0030", 32'(digits), 32'h0030);
        chk("adjmin_nowrap", 32'(wrap_count), 32'd0);
        adjust = 1'b0;
        t1(1);
        chk("adjmin_norm_0031", 32'(digits), 32'h0031);

        // same-cycle pause and tick
        do_reset();
        t1(5);
        @(negedge clk) begin pause = 1'b1; tick_1hz = 1'b1; end
        @(negedge clk) begin pause = 1'b0; tick_1hz = 1'b0; end
        chk("run_pause_tick_digits", 32'(digits), 32'h0006);
        chk("run_pause_tick_state", 32'(running), 32'd0);
        @(negedge clk) begin pause = 1'b1; tick_1hz = 1'b1; end
        @(negedge clk) begin pause = 1'b0; tick_1hz = 1'b0; end
        chk("paused_pause_tick_digits", 32'(digits), 32'h0006);
        chk("paused_pause_tick_state", 32'(running), 32'd1);

        // both ticks in normal mode: only 1 Hz counts (adjust would bump minutes)
        @(negedge clk) begin tick_1hz = 1'b1; tick_2hz = 1'b1; end
        @(negedge clk) begin tick_1hz = 1'b0; tick_2hz = 1'b0; end
        chk("both_ticks_normal", 32'(digits), 32'h0007);
        // adjust change in the same cycle as its tick
        @(negedge clk) begin adjust = 1'b1; select = 1'b0; tick_2hz = 1'b1; end
        @(negedge clk) begin adjust = 1'b0; tick_2hz = 1'b0; end
        chk("adjust_same_cycle", 32'(digits), 32'h0107);

        // asynchronous reset mid-cycle while paused at 12:34
        do_reset();
        load(12, 34);
        pause_pulse();
        chk("pre_async_digits", 32'(digits), 32'h1234);
        chk("pre_async_paused", 32'(running), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_digits", 32'(digits), 32'h0000);
        chk("async_rst_running", 32'(running), 32'd1);
        @(negedge clk) rst = 1'b0;
        t1(1);
        chk("post_rst_first_tick", 32'(digits), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
